// File: rtl/bomb_ctrl_pkg.sv
// ============================================================================
// Module : bomb_ctrl_pkg
// Brief  : Shared bomb life-cycle states, blast arm extents and coordinate helpers.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package bomb_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARMED    = 2'd1,
        BLAST    = 2'd2,
        COOLDOWN = 2'd3
    } bomb_state_e;

    localparam int TILE     = 16;
    localparam int ARM_NEG  = 48;
    localparam int ARM_POS  = 63;
    localparam int SPRITE_W = 16;
    localparam int SPRITE_H = 16;

    // Round to the nearest tile, then clamp to the last legal tile position.
    function automatic logic [9:0] snap_coord(input logic [9:0] v, input logic [10:0] max_pos);
        logic [10:0] s;
        s = {1'b0, v} + 11'(TILE / 2);
        s = s & ~(11'(TILE) - 11'd1);
        if (s > max_pos) begin
            s = max_pos;
        end
        return s[9:0];
    endfunction

    function automatic logic span_overlap(input logic [10:0] a_lo, input logic [10:0] a_hi,
                                          input logic [10:0] b_lo, input logic [10:0] b_hi);
        return (a_lo <= b_hi) && (b_lo <= a_hi);
    endfunction

endpackage

`default_nettype wire

// File: rtl/bomb_ctrl_blast_overlap.sv
// ============================================================================
// Module : blast_overlap
// Brief  : Combinational test of a sprite-sized box against the plus-shaped blast.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module blast_overlap
    import bomb_ctrl_pkg::*;
(
    input  logic [9:0] e_x_i,
    input  logic [9:0] e_y_i,
    input  logic [9:0] p_x_i,
    input  logic [9:0] p_y_i,
    output logic       hit_o
);

    logic [10:0] w_ex, w_ey, w_px, w_py;
    logic [10:0] w_ex_lo, w_ex_hi, w_ey_lo, w_ey_hi, w_ex_end, w_ey_end;
    logic [10:0] w_px_end, w_py_end;
    logic        w_h_hit, w_v_hit;

    // Eleven bits hold e+ARM_POS without wrap; lower arm ends saturate at zero.
    assign w_ex     = {1'b0, e_x_i};
    assign w_ey     = {1'b0, e_y_i};
    assign w_px     = {1'b0, p_x_i};
    assign w_py     = {1'b0, p_y_i};
    assign w_ex_lo  = (w_ex >= 11'(ARM_NEG)) ? (w_ex - 11'(ARM_NEG)) : 11'd0;
    assign w_ey_lo  = (w_ey >= 11'(ARM_NEG)) ? (w_ey - 11'(ARM_NEG)) : 11'd0;
    assign w_ex_hi  = w_ex + 11'(ARM_POS);
    assign w_ey_hi  = w_ey + 11'(ARM_POS);
    assign w_ex_end = w_ex + 11'(TILE - 1);
    assign w_ey_end = w_ey + 11'(TILE - 1);
    assign w_px_end = w_px + 11'(SPRITE_W - 1);
    assign w_py_end = w_py + 11'(SPRITE_H - 1);

    assign w_h_hit = span_overlap(w_ex_lo, w_ex_hi, w_px, w_px_end) &&
                     span_overlap(w_ey, w_ey_end, w_py, w_py_end);
    assign w_v_hit = span_overlap(w_ex, w_ex_end, w_px, w_px_end) &&
                     span_overlap(w_ey_lo, w_ey_hi, w_py, w_py_end);
    assign hit_o   = w_h_hit || w_v_hit;

endmodule

`default_nettype wire

// File: rtl/bomb_ctrl.sv
// ============================================================================
// Module : bomb_ctrl
// Brief  : One bomb's placement, fuse, blast, cooldown sequence and player hit flag.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bomb_ctrl
    import bomb_ctrl_pkg::*;
#(
    parameter int FUSE_TICKS     = 180,
    parameter int BLAST_TICKS    = 30,
    parameter int COOLDOWN_TICKS = 15,
    parameter int MAX_POS        = 1008
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       place_btn,
    input  logic [9:0] b_x,
    input  logic [9:0] b_y,
    output logic       ready,
    output logic       bomb_active,
    output logic       blast_on,
    output logic       explosion_SCEN,
    output logic [9:0] e_x,
    output logic [9:0] e_y,
    output logic       player_hit
);

    localparam int MAX_T1 = (FUSE_TICKS > BLAST_TICKS) ? FUSE_TICKS : BLAST_TICKS;
    localparam int MAX_T  = (MAX_T1 > COOLDOWN_TICKS) ? MAX_T1 : COOLDOWN_TICKS;
    localparam int CNT_W  = (MAX_T > 1) ? $clog2(MAX_T) : 1;

    localparam logic [CNT_W-1:0] FUSE_LOAD  = CNT_W'(FUSE_TICKS - 1);
    localparam logic [CNT_W-1:0] BLAST_LOAD = CNT_W'(BLAST_TICKS - 1);
    localparam logic [CNT_W-1:0] COOL_LOAD  = CNT_W'(COOLDOWN_TICKS - 1);
    localparam logic [10:0]      MAX_POS_C  = 11'(MAX_POS);

    bomb_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [9:0]       ex_q, ex_d, ey_q, ey_d;
    logic             btn_q, scen_q, scen_d, hit_q, hit_d;
    logic             ready_q, active_q, blast_q;
    logic             w_place_edge, w_overlap;

    assign w_place_edge = place_btn & ~btn_q;

    blast_overlap u_blast_overlap (
        .e_x_i (ex_q),
        .e_y_i (ey_q),
        .p_x_i (b_x),
        .p_y_i (b_y),
        .hit_o (w_overlap)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ex_d    = ex_q;
        ey_d    = ey_q;
        scen_d  = 1'b0;
        hit_d   = hit_q | ((state_q == BLAST) & w_overlap);
        case (state_q)
            IDLE: begin
                if (w_place_edge) begin
                    state_d = ARMED;
                    cnt_d   = FUSE_LOAD;
                    ex_d    = snap_coord(b_x, MAX_POS_C);
                    ey_d    = snap_coord(b_y, MAX_POS_C);
                end
            end
            ARMED: begin
                if (tick) begin
                    if (cnt_q == '0) begin
                        state_d = BLAST;
                        cnt_d   = BLAST_LOAD;
                        scen_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            BLAST: begin
                if (tick) begin
                    if (cnt_q == '0) begin
                        state_d = COOLDOWN;
                        cnt_d   = COOL_LOAD;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            COOLDOWN: begin
                if (tick) begin
                    if (cnt_q == '0) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Status flags are registered from the next state so they line up with state_q.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            ex_q     <= '0;
            ey_q     <= '0;
            btn_q    <= 1'b0;
            scen_q   <= 1'b0;
            hit_q    <= 1'b0;
            ready_q  <= 1'b1;
            active_q <= 1'b0;
            blast_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ex_q     <= ex_d;
            ey_q     <= ey_d;
            btn_q    <= place_btn;
            scen_q   <= scen_d;
            hit_q    <= hit_d;
            ready_q  <= (state_d == IDLE);
            active_q <= (state_d == ARMED);
            blast_q  <= (state_d == BLAST);
        end
    end

    assign ready          = ready_q;
    assign bomb_active    = active_q;
    assign blast_on       = blast_q;
    assign explosion_SCEN = scen_q;
    assign e_x            = ex_q;
    assign e_y            = ey_q;
    assign player_hit     = hit_q;

endmodule

`default_nettype wire

// File: tb/tb_bomb_ctrl.sv
// ============================================================================
// Module : tb_bomb_ctrl
// Brief  : Scoreboard bench for bomb_ctrl against a tick-count reference model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bomb_ctrl;

    localparam int FUSE = 3;
    localparam int BLST = 2;
    localparam int COOL = 2;
    localparam int MAXP = 1008;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic       place_btn = 1'b0;
    logic [9:0] b_x = '0;
    logic [9:0] b_y = '0;
    logic       ready, bomb_active, blast_on, explosion_SCEN, player_hit;
    logic [9:0] e_x, e_y;

    bomb_ctrl #(
        .FUSE_TICKS     (FUSE),
        .BLAST_TICKS    (BLST),
        .COOLDOWN_TICKS (COOL),
        .MAX_POS        (MAXP)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .tick           (tick),
        .place_btn      (place_btn),
        .b_x            (b_x),
        .b_y            (b_y),
        .ready          (ready),
        .bomb_active    (bomb_active),
        .blast_on       (blast_on),
        .explosion_SCEN (explosion_SCEN),
        .e_x            (e_x),
        .e_y            (e_y),
        .player_hit     (player_hit)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit rdy;
        bit act;
        bit blast;
        bit scen;
        int ex;
        int ey;
        bit hit;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: a bomb is "ticks elapsed since placement"; phases follow from sums.
    bit m_active = 0;
    int m_ticks  = 0;
    int m_ex     = 0;
    int m_ey     = 0;
    bit m_hit    = 0;
    bit m_prev   = 0;
    bit m_scen   = 0;

    function automatic void chk(string nm, int act, int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s at %0t: actual=%0d expected=%0d", nm, $time, act, expv);
        end
    endfunction

    function automatic int snap_ref(int v);
        int s;
        s = ((v + 8) / 16) * 16;
        return (s > MAXP) ? MAXP : s;
    endfunction

    function automatic bit rect_ovl(int ax0, int ax1, int ay0, int ay1,
                                    int bx0, int bx1, int by0, int by1);
        return !(ax1 < bx0 || bx1 < ax0 || ay1 < by0 || by1 < ay0);
    endfunction

    function automatic bit plus_hit(int px, int py);
        int lox, loy;
        lox = (m_ex - 48 < 0) ? 0 : m_ex - 48;
        loy = (m_ey - 48 < 0) ? 0 : m_ey - 48;
        return rect_ovl(lox, m_ex + 63, m_ey, m_ey + 15, px, px + 15, py, py + 15) ||
               rect_ovl(m_ex, m_ex + 15, loy, m_ey + 63, px, px + 15, py, py + 15);
    endfunction

    function automatic bit in_blast();
        return m_active && m_ticks >= FUSE && m_ticks < FUSE + BLST;
    endfunction

    task automatic cycle(bit rst, bit tk, bit btn, int px, int py);
        exp_t e;
        bit   edge_s;
        @(negedge clk);
        reset     = rst;
        tick      = tk;
        place_btn = btn;
        b_x       = 10'(px);
        b_y       = 10'(py);
        if (rst) begin
            m_active = 0; m_ticks = 0; m_ex = 0; m_ey = 0;
            m_hit = 0; m_prev = 0; m_scen = 0;
        end else begin
            edge_s = btn && !m_prev;
            m_prev = btn;
            m_scen = 0;
            if (m_active) begin
                if (in_blast() && plus_hit(px, py)) m_hit = 1;
                if (tk) begin
                    m_ticks++;
                    if (m_ticks == FUSE) m_scen = 1;
                    if (m_ticks == FUSE + BLST + COOL) m_active = 0;
                end
            end else if (edge_s) begin
                m_active = 1;
                m_ticks  = 0;
                m_ex     = snap_ref(px);
                m_ey     = snap_ref(py);
            end
        end
        e.rdy   = !m_active;
        e.act   = m_active && m_ticks < FUSE;
        e.blast = in_blast();
        e.scen  = m_scen;
        e.ex    = m_ex;
        e.ey    = m_ey;
        e.hit   = m_hit;
        sb.push_back(e);
    endtask

    task automatic run(int n, bit tk, bit btn, int px, int py);
        for (int i = 0; i < n; i++) cycle(1'b0, tk, btn, px, py);
    endtask

    // Monitor: every clock the DUT presents a fresh registered output set.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("ready",          int'(ready),          int'(e.rdy));
            chk("bomb_active",    int'(bomb_active),    int'(e.act));
            chk("blast_on",       int'(blast_on),       int'(e.blast));
            chk("explosion_SCEN", int'(explosion_SCEN), int'(e.scen));
            chk("e_x",            int'(e_x),            e.ex);
            chk("e_y",            int'(e_y),            e.ey);
            chk("player_hit",     int'(player_hit),     int'(e.hit));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        int px, py;
        bit btn;
        cycle(1'b1, 0, 0, 0, 0);
        cycle(1'b1, 0, 0, 0, 0);

        // Basic placement with rounding, full life cycle.
        run(1, 0, 0, 301, 107);
        run(1, 0, 1, 301, 107);
        @(posedge clk); #2;
        chk("snap_e_x", int'(e_x), 304);
        chk("snap_e_y", int'(e_y), 112);
        run(1, 0, 0, 0, 0);
        run(8, 1, 0, 0, 0);

        // Button held through the whole sequence, then re-pressed.
        run(12, 1, 1, 100, 100);
        run(2, 0, 0, 100, 100);
        run(1, 0, 1, 200, 200);
        run(8, 1, 0, 200, 200);

        // Presses while armed and in cooldown are ignored.
        run(1, 0, 1, 40, 40);
        run(1, 1, 0, 40, 40);
        run(1, 0, 1, 600, 600);
        run(1, 1, 0, 600, 600);
        run(3, 1, 0, 600, 600);
        run(1, 0, 1, 700, 700);
        run(4, 1, 0, 700, 700);

        // Hit geometry: horizontal arm edge, just outside, vertical arm.
        cycle(1'b1, 0, 0, 0, 0);
        run(1, 0, 1, 301, 107);
        run(3, 1, 0, 352, 112);
        run(3, 0, 0, 352, 112);
        @(posedge clk); #2;
        chk("hit_h_arm", int'(player_hit), 1);
        run(5, 1, 0, 352, 112);
        cycle(1'b1, 0, 0, 0, 0);
        run(1, 0, 1, 301, 107);
        run(3, 1, 0, 368, 112);
        run(3, 0, 0, 368, 112);
        run(4, 1, 0, 368, 112);
        @(posedge clk); #2;
        chk("miss_h_arm", int'(player_hit), 0);
        cycle(1'b1, 0, 0, 0, 0);
        run(1, 0, 1, 301, 107);
        run(3, 1, 0, 304, 60);
        run(6, 1, 0, 304, 60);

        // Reset during the fuse kills the bomb with no pulse.
        cycle(1'b1, 0, 0, 0, 0);
        run(1, 0, 1, 500, 500);
        run(2, 1, 0, 500, 500);
        cycle(1'b1, 0, 0, 0, 0);
        run(10, 1, 0, 500, 500);

        // Clamp at the far edge, then lower-bound saturation near the origin.
        run(1, 0, 1, 1020, 0);
        @(posedge clk); #2;
        chk("clamp_e_x", int'(e_x), 1008);
        chk("clamp_e_y", int'(e_y), 0);
        run(3, 1, 0, 0, 0);
        run(5, 1, 0, 0, 0);
        run(1, 0, 1, 5, 3);
        run(3, 1, 0, 0, 0);
        run(5, 1, 0, 0, 40);

        // Randomized traffic, player biased toward the live bomb.
        btn = 0;
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 3) == 0) btn = !btn;
            if (m_active) begin
                px = m_ex + int'($urandom_range(0, 160)) - 80;
                py = m_ey + int'($urandom_range(0, 160)) - 80;
                px = (px < 0) ? 0 : (px > 1023) ? 1023 : px;
                py = (py < 0) ? 0 : (py > 1023) ? 1023 : py;
            end else begin
                px = int'($urandom_range(0, 1023));
                py = int'($urandom_range(0, 1023));
            end
            cycle($urandom_range(0, 299) == 0, $urandom_range(0, 2) == 0, btn, px, py);
        end

        repeat (3) @(posedge clk);
        #2;
        chk("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
